// File: rtl/sub_bytes_seq.sv
// Multi-cycle AES SubBytes engine: substitutes LANES bytes of a 128-bit state per clock.
// S-box values are computed as GF(2^8) inverse plus the affine map, so each lane is a pure combinational ROM.
module sub_bytes_seq #(
  parameter int LANES      = 4,
  parameter bit INVERSE_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         inv,
  input  logic [127:0] data_in,
  output logic         ready,
  output logic         done,
  output logic [127:0] data_out
);

  localparam int         N        = 16 / LANES;
  localparam logic [3:0] LAST_GRP = 4'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 = a^2 * a^4 * ... * a^128 is the multiplicative inverse, and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    return gf_inv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
  endfunction

  fsm_e         fsm_q;
  logic [3:0]   cnt_q;
  logic         mode_q;
  logic         ready_q;
  logic         done_q;
  logic [127:0] state_q;
  logic [127:0] data_out_q;
  logic [127:0] state_d;

  logic [7:0] lane_in  [LANES];
  logic [7:0] lane_out [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = state_q[127 - 8 * (int'(cnt_q) * LANES + l) -: 8];
    end
  end

  for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
    logic [7:0] fwd_byte;
    assign fwd_byte = sbox_fwd(lane_in[gl]);
    if (INVERSE_EN) begin : g_inv
      logic [7:0] inv_byte;
      assign inv_byte     = sbox_inv(lane_in[gl]);
      assign lane_out[gl] = mode_q ? inv_byte : fwd_byte;
    end else begin : g_fwd_only
      assign lane_out[gl] = fwd_byte;
    end
  end

  // Only the current group's bytes change; every other byte passes through.
  always_comb begin
    state_d = state_q;
    for (int l = 0; l < LANES; l++) begin
      state_d[127 - 8 * (int'(cnt_q) * LANES + l) -: 8] = lane_out[l];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q      <= IDLE;
      cnt_q      <= 4'd0;
      mode_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      // NOTE: the working state is reset too, so an aborted operation leaves no key-dependent bytes behind.
      state_q    <= '0;
      data_out_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      case (fsm_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= data_in;
            mode_q  <= inv & INVERSE_EN;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            fsm_q   <= RUN;
          end
        end
        RUN: begin
          state_q <= state_d;
          if (cnt_q == LAST_GRP) begin
            cnt_q      <= 4'd0;
            data_out_q <= state_d;
            done_q     <= 1'b1;
            fsm_q      <= DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          fsm_q   <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          fsm_q   <= IDLE;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq: five instances cover LANES=4/1/16/2 and a forward-only build.
// Expected bytes are the FIPS-197 table values 00->63, 53->ED, FF->16 and their inverses.
module tb_sub_bytes_seq;

  localparam logic [127:0] ALL_FF = {16{8'hff}};
  localparam logic [127:0] ALL_16 = {16{8'h16}};
  localparam logic [127:0] ALL_63 = {16{8'h63}};
  localparam logic [127:0] MIX_IN = 128'h00530000000000000000000000000000;
  localparam logic [127:0] MIX_S  = 128'h63ED6363636363636363636363636363;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   start;
  logic         inv;
  logic [127:0] data_in;
  logic [4:0]   ready;
  logic [4:0]   done;
  logic [127:0] dout [5];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Instance index: 0 = LANES 4, 1 = LANES 1, 2 = LANES 16, 3 = LANES 2, 4 = LANES 4 forward only.
  sub_bytes_seq #(.LANES(4),  .INVERSE_EN(1'b1)) u_l4  (.clk(clk), .rst(rst), .start(start[0]), .inv(inv),
    .data_in(data_in), .ready(ready[0]), .done(done[0]), .data_out(dout[0]));
  sub_bytes_seq #(.LANES(1),  .INVERSE_EN(1'b1)) u_l1  (.clk(clk), .rst(rst), .start(start[1]), .inv(inv),
    .data_in(data_in), .ready(ready[1]), .done(done[1]), .data_out(dout[1]));
  sub_bytes_seq #(.LANES(16), .INVERSE_EN(1'b1)) u_l16 (.clk(clk), .rst(rst), .start(start[2]), .inv(inv),
    .data_in(data_in), .ready(ready[2]), .done(done[2]), .data_out(dout[2]));
  sub_bytes_seq #(.LANES(2),  .INVERSE_EN(1'b1)) u_l2  (.clk(clk), .rst(rst), .start(start[3]), .inv(inv),
    .data_in(data_in), .ready(ready[3]), .done(done[3]), .data_out(dout[3]));
  sub_bytes_seq #(.LANES(4),  .INVERSE_EN(1'b0)) u_l4f (.clk(clk), .rst(rst), .start(start[4]), .inv(inv),
    .data_in(data_in), .ready(ready[4]), .done(done[4]), .data_out(dout[4]));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one operation on instance idx and check latency, result and handshake timing.
  task automatic run_op(input int idx, input logic [127:0] din, input logic iv,
                        input int exp_lat, input logic [127:0] exp, input string tag);
    int   lat;
    logic rdy_at_done;
    @(negedge clk);
    data_in    = din;
    inv        = iv;
    start[idx] = 1'b1;
    @(posedge clk);
    #1;
    start[idx]  = 1'b0;
    data_in     = ~din;
    inv         = ~iv;
    lat         = 0;
    rdy_at_done = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done[idx]) begin
        lat         = k;
        rdy_at_done = ready[idx];
        break;
      end
    end
    check({tag, " latency"}, 128'(lat), 128'(exp_lat));
    check({tag, " data_out"}, dout[idx], exp);
    check({tag, " ready at done"}, 128'(rdy_at_done), 128'(1'b0));
    @(posedge clk);
    #1;
    check({tag, " ready after done"}, 128'({ready[idx], done[idx]}), 128'(2'b10));
  endtask

  initial begin
    int n_done;
    int first_done;
    int second_done;

    rst     = 1'b0;
    start   = '1;
    inv     = 1'b0;
    data_in = ALL_FF;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 128'(ready), 128'(5'b11111));
    check("reset done", 128'(done), 128'(5'b00000));
    check("reset data_out l4", dout[0], 128'h0);
    check("reset data_out l1", dout[1], 128'h0);
    @(negedge clk);
    start = '0;
    rst   = 1'b1;

    run_op(0, ALL_FF, 1'b0, 4,  ALL_16, "fwd l4 ff");
    run_op(1, MIX_IN, 1'b0, 16, MIX_S,  "fwd l1 mix");
    run_op(2, MIX_IN, 1'b0, 1,  MIX_S,  "fwd l16 mix");
    run_op(0, ALL_16, 1'b1, 4,  ALL_FF, "inv l4 16");
    run_op(1, MIX_S,  1'b1, 16, MIX_IN, "inv l1 mix");
    run_op(4, ALL_FF, 1'b1, 4,  ALL_16, "inv ignored l4f");
    check("l16 holds result", dout[2], MIX_S);

    // Busy: a second start during RUN must be dropped.
    @(negedge clk);
    data_in  = ALL_FF;
    inv      = 1'b0;
    start[3] = 1'b1;
    @(negedge clk);
    start[3] = 1'b0;
    repeat (3) @(negedge clk);
    data_in  = ALL_63;
    start[3] = 1'b1;
    @(negedge clk);
    start[3] = 1'b0;
    n_done   = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done[3]) n_done++;
    end
    check("busy done count", 128'(n_done), 128'(1));
    check("busy data_out", dout[3], ALL_16);
    check("busy ready idle", 128'(ready[3]), 128'(1'b1));

    // Held start: back-to-back operations every N+2 = 10 cycles.
    @(negedge clk);
    data_in     = MIX_IN;
    start[3]    = 1'b1;
    first_done  = 0;
    second_done = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done[3]) begin
        if (first_done == 0) first_done = c;
        else begin
          second_done = c;
          break;
        end
      end
    end
    start[3] = 1'b0;
    check("held start first done", 128'(first_done), 128'(9));
    check("held start period", 128'(second_done - first_done), 128'(10));
    check("held start data_out", dout[3], MIX_S);
    repeat (2) @(posedge clk);

    // Reset mid-run at group 7 of the LANES=1 instance.
    @(negedge clk);
    data_in  = ALL_FF;
    inv      = 1'b0;
    start[1] = 1'b1;
    @(posedge clk);
    #1;
    start[1] = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async reset data_out l1", dout[1], 128'h0);
    check("async reset data_out l4", dout[0], 128'h0);
    check("async reset ready", 128'(ready), 128'(5'b11111));
    check("async reset done", 128'(done), 128'(5'b00000));
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done[1]) n_done++;
    end
    check("abort no done", 128'(n_done), 128'(0));
    check("abort data_out", dout[1], 128'h0);
    run_op(1, 128'h0, 1'b0, 16, ALL_63, "fwd l1 after abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sub_bytes_seq.md
# sub_bytes_seq

Parametrised, multi-cycle AES SubBytes engine: substitutes the 16 bytes of a 128-bit AES state through the forward or, optionally, inverse S-box, LANES bytes per clock. It sits in the round datapath between AddRoundKey and ShiftRows. It trades area for latency against the single-cycle sub_bytes, and adds a start/done handshake and a per-operation direction select.

## Interface
- LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16. Any other value is a compile-time error.
- INVERSE_EN, 1, 1 = build the inverse S-box and honour `inv`; 0 = forward only, `inv` ignored.
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  request a new operation; accepted only when `ready`=1.
- inv  input  1  0 = forward S-box, 1 = inverse S-box; sampled with `start`.
- data_in  input  128  state to substitute; sampled with `start`.
- ready  output  1  engine idle, can accept `start`.
- done  output  1  one-cycle pulse: `data_out` has just been updated with a finished result.
- data_out  output  128  last finished result; holds until the next `done`.

## Operation
- Byte numbering: byte i = data[127-8i -: 8], so byte 0 is the MSB (FIPS-197 input order).
- N = 16/LANES groups; group g covers bytes g*LANES .. g*LANES+LANES-1.
- The FSM has three states: IDLE, RUN and DONE.
- IDLE: `ready`=1. On `start`=1, the engine:
  - loads `data_in` into the internal state register,
  - latches the mode (`inv` AND INVERSE_EN),
  - sets the 4-bit group counter to 0 and moves to RUN.
- RUN:
  - Each cycle replaces the bytes of group counter with S(byte), or S^-1(byte) if the latched mode is set. All other bytes hold.
  - The counter then increments.
  - When the last group (counter = N-1) is written, the FSM moves to DONE, and `data_out` is loaded with the fully substituted state on that same edge.
- DONE: `done`=1 for exactly this cycle, `ready`=0. The FSM goes unconditionally to IDLE on the next edge.
- `start` while `ready`=0 is ignored: it is not queued and causes no error flag.
- `data_in` and `inv` changes after acceptance have no effect on the running operation.
- The S-boxes are combinational ROMs, LANES copies of each. The inverse ROMs are absent when INVERSE_EN=0.

## Timing
- Reset (`rst`=0, asynchronous) puts the block in this state:
  - FSM = IDLE, `ready`=1, `done`=0, `data_out`=128'h0, counter=0, internal state=0.
- Reset asserted mid-operation aborts the operation: no `done` is produced and `data_out` returns to 0.
- Release is synchronous to clk; `start` is honoured from the first rising edge at which `rst`=1.
- Latency: `start` sampled at edge E → RUN at E; group writes at edges E+1..E+N; `done`=1 and new `data_out` after edge E+N; `ready`=1 again after edge E+N+1.
  - LANES=16: `done` 1 cycle after acceptance.
  - LANES=4: 4 cycles.
  - LANES=1: 16 cycles.
- Throughput: one operation per N+2 cycles when `start` is held high.
- `ready` deasserts the cycle after acceptance and stays low through DONE.
- Counter wrap does not occur; the counter is reset on every acceptance.
- `data_out` is stable and glitch-free between `done` pulses, including during a following operation.

## Test plan
- Reset value: hold `rst`=0 with `data_in` all ones and `start`=1. Required: `ready`=1, `done`=0, `data_out`=0, no operation starts. Assert `rst`=0 asynchronously between edges and check the outputs clear immediately.
- Forward, LANES=4: `start` with `data_in`=128'hffffffffffffffffffffffffffffffff, `inv`=0. Required: `done` 4 cycles later, `data_out`=128'h16161616161616161616161616161616.
- Mixed bytes, forward, LANES=1 and LANES=16: `data_in`=128'h00530000000000000000000000000000. Required: `data_out`=128'h63ED6363636363636363636363636363, with `done` at 16 and 1 cycles after acceptance respectively.
- Inverse, INVERSE_EN=1: `start` with the previous result and `inv`=1. Required: the original `data_in` is returned; 0x16→0xFF, 0x63→0x00, 0xED→0x53. With INVERSE_EN=0 and `inv`=1, the result equals the forward result.
- Busy behaviour, LANES=2: pulse `start` with a second `data_in` while `ready`=0. Required: the request is ignored, only one `done`, and `data_out` equals the first operation's result. Held `start` gives back-to-back operations every 10 cycles.
- Reset mid-run, LANES=1: assert `rst`=0 at group 7. Required: no `done`, `data_out`=0, `ready`=1. A fresh `start` after release completes normally.
